// File: rtl/mem_if_pkg.sv
// Shared types and width helpers for the burst memory interface.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    XFER,
    DONE
  } state_e;

  function automatic int unsigned beat_w(
    input int unsigned n
  );
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned cnt_w(
    input int unsigned n
  );
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/burst_memory_interface_if.sv
// Requester <-> memory handshake bundle.
interface burst_memory_interface_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 64
);

  logic              enable;
  logic              rd_wrt_mem;
  logic              burst;
  logic [ADDR_W-1:0] addr_mem;
  logic [DATA_W-1:0] data_mem_in;
  logic              beat_ack;
  logic [DATA_W-1:0] data_mem_out;
  logic              rd_valid;
  logic              busy;
  logic              done;
  logic              par_err;

  modport master (
    output enable,
    output rd_wrt_mem,
    output burst,
    output addr_mem,
    output data_mem_in,
    input  beat_ack,
    input  data_mem_out,
    input  rd_valid,
    input  busy,
    input  done,
    input  par_err
  );

  modport slave (
    input  enable,
    input  rd_wrt_mem,
    input  burst,
    input  addr_mem,
    input  data_mem_in,
    output beat_ack,
    output data_mem_out,
    output rd_valid,
    output busy,
    output done,
    output par_err
  );

endinterface

// File: rtl/burst_memory_interface_mem_array.sv
// Word storage with registered read port.
// MEM_PARITY_EN adds an even-parity column checked on read.
module mem_array #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_par_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

`ifdef MEM_PARITY_EN
  logic r_par [DEPTH];
  logic r_perr;

  always_ff @(posedge clk) begin
    if (i_we) r_par[i_waddr] <= ^i_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_perr <= 1'b0;
    else if (i_re) r_perr <= r_par[i_raddr] ^ (^r_mem[i_raddr]);
  end

  assign o_par_err = r_perr;
`else
  assign o_par_err = 1'b0;
`endif

endmodule

// File: rtl/burst_memory_interface.sv
// Burst memory model: FSM, latency counter, wrapping beat address.
// Optional MEM_PARITY_EN enables stored-word parity checking.
module burst_memory_interface
  import mem_if_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 4,
  parameter int LATENCY   = 2
) (
  input logic clk,
  input logic rst,
  burst_memory_interface_if.slave bus
);

  localparam int BW = beat_w(BURST_LEN);
  localparam int CW = cnt_w(LATENCY);

  state_e            r_state;
  state_e            w_next;
  logic [CW-1:0]     r_cnt;
  logic [BW-1:0]     r_beat;
  logic              r_rd;
  logic              r_burst;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rd_valid;

  logic              w_last;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_addr;
  logic [BW-1:0]     w_low;

  assign w_xfer = (r_state == XFER);
  assign w_last = !r_burst || (r_beat == BW'(BURST_LEN - 1));

  // single beats use r_beat == 0, so the wrap sum leaves addr intact
  assign w_low  = r_addr[BW-1:0] + r_beat;
  assign w_addr = {r_addr[ADDR_W-1:BW], w_low};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.enable) w_next = WAIT;
      WAIT:    if (r_cnt == '0) w_next = XFER;
      XFER:    if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_beat     <= '0;
      r_rd       <= 1'b0;
      r_burst    <= 1'b0;
      r_addr     <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_xfer && r_rd;
      if (r_state == IDLE && bus.enable) begin
        r_cnt   <= CW'(LATENCY - 1);
        r_beat  <= '0;
        r_rd    <= bus.rd_wrt_mem;
        r_burst <= bus.burst;
        r_addr  <= bus.addr_mem;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - CW'(1);
      end else if (w_xfer) begin
        r_beat <= r_beat + BW'(1);
      end
    end
  end

  mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_xfer && !r_rd),
    .i_waddr  (w_addr),
    .i_wdata  (bus.data_mem_in),
    .i_re     (w_xfer && r_rd),
    .i_raddr  (w_addr),
    .o_rdata  (bus.data_mem_out),
    .o_par_err(bus.par_err)
  );

  assign bus.beat_ack = w_xfer;
  assign bus.rd_valid = r_rd_valid;
  assign bus.busy     = (r_state != IDLE);
  assign bus.done     = (r_state == DONE);

endmodule
